// File: rtl/hazard_pkg.sv
// Shared widths, Tuse/Tnew classes, forwarding select encodings and the shadow-entry type
// for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned TIME_W = 2;

  localparam logic [TIME_W-1:0] TUSE_BR   = 2'd0;
  localparam logic [TIME_W-1:0] TUSE_ALU  = 2'd1;
  localparam logic [TIME_W-1:0] TUSE_ST   = 2'd2;
  localparam logic [TIME_W-1:0] TUSE_NONE = 2'd3;

  localparam logic [TIME_W-1:0] TNEW_LINK = 2'd0;
  localparam logic [TIME_W-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TIME_W-1:0] TNEW_LOAD = 2'd2;

  localparam logic [1:0] FWD_D_GRF = 2'd0;
  localparam logic [1:0] FWD_D_E   = 2'd1;
  localparam logic [1:0] FWD_D_M   = 2'd2;

  localparam logic [1:0] FWD_E_REG = 2'd0;
  localparam logic [1:0] FWD_E_M   = 2'd1;
  localparam logic [1:0] FWD_E_W   = 2'd2;

  localparam logic FWD_M_REG = 1'b0;
  localparam logic FWD_M_W   = 1'b1;

  typedef struct packed {
    logic              we;
    logic [REG_W-1:0]  a3;
    logic [TIME_W-1:0] tnew;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
  } shadow_t;

  // A producer only matters if it writes a real register that the consumer names.
  function automatic logic hit(shadow_t s, logic [REG_W-1:0] r);
    return s.we && (s.a3 == r) && (r != '0);
  endfunction

  function automatic logic [TIME_W-1:0] tnew_dec(logic [TIME_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/hazard_track_reg.sv
// One shadow pipeline entry: synchronous reset, bubble insert on clr, optional
// saturating Tnew decrement as the instruction advances.
module hazard_track_reg
  import hazard_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    clr,
  input  logic    dec,
  input  shadow_t d,
  output shadow_t q
);

  shadow_t nxt;

  always_comb begin
    nxt = d;
    if (dec) begin
      nxt.tnew = tnew_dec(d.tnew);
    end
    if (clr) begin
      nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall and forwarding controller for the 5-stage pipeline.
// Define HAZ_FWD_EN to build forwarding with Tnew/Tuse stalls; otherwise interlock-only.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  D_rs,
  input  logic [REG_W-1:0]  D_rt,
  input  logic [TIME_W-1:0] D_Tuse_rs,
  input  logic [TIME_W-1:0] D_Tuse_rt,
  input  logic              D_we,
  input  logic [REG_W-1:0]  D_A3,
  input  logic [TIME_W-1:0] D_Tnew,
  output logic              stall,
  output logic              E_clr,
  output logic [1:0]        fwd_D_rs,
  output logic [1:0]        fwd_D_rt,
  output logic [1:0]        fwd_E_rs,
  output logic [1:0]        fwd_E_rt,
  output logic              fwd_M_rt
);

  shadow_t d_entry;
  shadow_t e_q;
  shadow_t m_q;
  shadow_t w_q;

  assign d_entry = '{we: D_we, a3: D_A3, tnew: D_Tnew, rs: D_rs, rt: D_rt};

  // Tnew in E is taken as-is; it starts counting down once the instruction leaves E.
  hazard_track_reg u_track_e (
    .clk  (clk),
    .reset(reset),
    .clr  (stall),
    .dec  (1'b0),
    .d    (d_entry),
    .q    (e_q)
  );

  hazard_track_reg u_track_m (
    .clk  (clk),
    .reset(reset),
    .clr  (1'b0),
    .dec  (1'b1),
    .d    (e_q),
    .q    (m_q)
  );

  hazard_track_reg u_track_w (
    .clk  (clk),
    .reset(reset),
    .clr  (1'b0),
    .dec  (1'b1),
    .d    (m_q),
    .q    (w_q)
  );

  assign E_clr = stall;

`ifdef HAZ_FWD_EN

  function automatic logic stall_on(shadow_t s, logic [REG_W-1:0] r, logic [TIME_W-1:0] tuse);
    return hit(s, r) && (tuse < s.tnew);
  endfunction

  function automatic logic [1:0] fwd_d_sel(shadow_t e, shadow_t m, logic [REG_W-1:0] r);
    if (hit(e, r) && (e.tnew == '0)) begin
      return FWD_D_E;
    end else if (hit(m, r) && (m.tnew == '0)) begin
      return FWD_D_M;
    end
    return FWD_D_GRF;
  endfunction

  function automatic logic [1:0] fwd_e_sel(shadow_t m, shadow_t w, logic [REG_W-1:0] r);
    if (hit(m, r) && (m.tnew == '0)) begin
      return FWD_E_M;
    end else if (hit(w, r)) begin
      return FWD_E_W;
    end
    return FWD_E_REG;
  endfunction

  always_comb begin
    stall    = stall_on(e_q, D_rs, D_Tuse_rs) | stall_on(e_q, D_rt, D_Tuse_rt) |
               stall_on(m_q, D_rs, D_Tuse_rs) | stall_on(m_q, D_rt, D_Tuse_rt);
    fwd_D_rs = fwd_d_sel(e_q, m_q, D_rs);
    fwd_D_rt = fwd_d_sel(e_q, m_q, D_rt);
    fwd_E_rs = fwd_e_sel(m_q, w_q, e_q.rs);
    fwd_E_rt = fwd_e_sel(m_q, w_q, e_q.rt);
    fwd_M_rt = hit(w_q, m_q.rt) ? FWD_M_W : FWD_M_REG;
  end

  logic unused_shadow;
  assign unused_shadow = ^{m_q.rs, w_q.tnew, w_q.rs, w_q.rt};

`else

  // Without forwarding any in-flight producer blocks a used operand until it reaches W.
  function automatic logic stall_on(shadow_t s, logic [REG_W-1:0] r, logic [TIME_W-1:0] tuse);
    return hit(s, r) && (tuse != TUSE_NONE);
  endfunction

  always_comb begin
    stall    = stall_on(e_q, D_rs, D_Tuse_rs) | stall_on(e_q, D_rt, D_Tuse_rt) |
               stall_on(m_q, D_rs, D_Tuse_rs) | stall_on(m_q, D_rt, D_Tuse_rt);
    fwd_D_rs = FWD_D_GRF;
    fwd_D_rt = FWD_D_GRF;
    fwd_E_rs = FWD_E_REG;
    fwd_E_rt = FWD_E_REG;
    fwd_M_rt = FWD_M_REG;
  end

  logic unused_shadow;
  assign unused_shadow = ^{e_q.tnew, e_q.rs, e_q.rt, m_q.tnew, m_q.rs, m_q.rt, w_q};

`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector tables, multi-cycle corner
// sequences and randomized stimulus against an age-indexed pipeline model.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_A3;
  logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
  logic       D_we;
  logic       stall, E_clr, fwd_M_rt;
  logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt;

  int vectors;
  int miscompares;

  hazard_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .D_rs     (D_rs),
    .D_rt     (D_rt),
    .D_Tuse_rs(D_Tuse_rs),
    .D_Tuse_rt(D_Tuse_rt),
    .D_we     (D_we),
    .D_A3     (D_A3),
    .D_Tnew   (D_Tnew),
    .stall    (stall),
    .E_clr    (E_clr),
    .fwd_D_rs (fwd_D_rs),
    .fwd_D_rt (fwd_D_rt),
    .fwd_E_rs (fwd_E_rs),
    .fwd_E_rt (fwd_E_rt),
    .fwd_M_rt (fwd_M_rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    bit         rst;
    string      name;
    logic [4:0] rs, rt, a3;
    logic [1:0] turs, turt, tnew;
    logic       we;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Expected outputs packed as {stall, E_clr, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt}.
  task automatic add(string nm, int rs, int rt, int turs, int turt, int we, int a3, int tnew,
                     int st, int fdrs, int fdrt, int fers, int fert, int fmrt);
    vec_t v;
    v.rst  = 1'b0;
    v.name = nm;
    v.rs   = 5'(rs);
    v.rt   = 5'(rt);
    v.turs = 2'(turs);
    v.turt = 2'(turt);
    v.we   = 1'(we);
    v.a3   = 5'(a3);
    v.tnew = 2'(tnew);
    v.exp  = {1'(st), 1'(st), 2'(fdrs), 2'(fdrt), 2'(fers), 2'(fert), 1'(fmrt)};
    tbl.push_back(v);
  endtask

  task automatic add_rst();
    vec_t v;
    v.rst  = 1'b1;
    v.name = "reset";
    v.rs   = '0;
    v.rt   = '0;
    v.turs = '0;
    v.turt = '0;
    v.we   = 1'b0;
    v.a3   = '0;
    v.tnew = '0;
    v.exp  = '0;
    tbl.push_back(v);
  endtask

  task automatic drive(int rs, int rt, int turs, int turt, int we, int a3, int tnew);
    D_rs      = 5'(rs);
    D_rt      = 5'(rt);
    D_Tuse_rs = 2'(turs);
    D_Tuse_rt = 2'(turt);
    D_we      = 1'(we);
    D_A3      = 5'(a3);
    D_Tnew    = 2'(tnew);
  endtask

  task automatic check(string nm, logic [10:0] exp);
    logic [10:0] act;
    act = {stall, E_clr, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b want %b (stall,clr,fDrs,fDrt,fErs,fErt,fMrt)",
               nm, $time, act, exp);
    end
  endtask

  // Reference model: in-flight instructions indexed by age (0=E, 1=M, 2=W), each keeping
  // the Tnew it had when it entered E; remaining time is derived from the age.
  logic       mdl_we[3];
  logic [4:0] mdl_a3[3], mdl_rs[3], mdl_rt[3];
  int         mdl_tn[3];

  function automatic int rem(int age);
    return (mdl_tn[age] > age) ? mdl_tn[age] - age : 0;
  endfunction

  function automatic bit mhit(int age, logic [4:0] r);
    return mdl_we[age] && (mdl_a3[age] == r) && (r != 5'd0);
  endfunction

  function automatic bit blocks(int age, logic [4:0] r, logic [1:0] tuse);
`ifdef HAZ_FWD_EN
    return mhit(age, r) && (int'(tuse) < rem(age));
`else
    return mhit(age, r) && (tuse != 2'd3);
`endif
  endfunction

  function automatic logic [1:0] exp_d(logic [4:0] r);
`ifdef HAZ_FWD_EN
    if (mhit(0, r) && rem(0) == 0) return 2'd1;
    if (mhit(1, r) && rem(1) == 0) return 2'd2;
`endif
    return 2'd0;
  endfunction

  function automatic logic [1:0] exp_e(logic [4:0] r);
`ifdef HAZ_FWD_EN
    if (mhit(1, r) && rem(1) == 0) return 2'd1;
    if (mhit(2, r)) return 2'd2;
`endif
    return 2'd0;
  endfunction

  function automatic logic [10:0] model_out();
    bit st;
    bit fm;
    st = 1'b0;
    for (int a = 0; a < 2; a++) begin
      if (blocks(a, D_rs, D_Tuse_rs) || blocks(a, D_rt, D_Tuse_rt)) st = 1'b1;
    end
    fm = 1'b0;
`ifdef HAZ_FWD_EN
    fm = mhit(2, mdl_rt[1]);
`endif
    return {st, st, exp_d(D_rs), exp_d(D_rt), exp_e(mdl_rs[0]), exp_e(mdl_rt[0]), fm};
  endfunction

  task automatic model_clear();
    for (int a = 0; a < 3; a++) begin
      mdl_we[a] = 1'b0;
      mdl_a3[a] = '0;
      mdl_rs[a] = '0;
      mdl_rt[a] = '0;
      mdl_tn[a] = 0;
    end
  endtask

  task automatic model_step(bit st);
    for (int a = 2; a > 0; a--) begin
      mdl_we[a] = mdl_we[a-1];
      mdl_a3[a] = mdl_a3[a-1];
      mdl_rs[a] = mdl_rs[a-1];
      mdl_rt[a] = mdl_rt[a-1];
      mdl_tn[a] = mdl_tn[a-1];
    end
    mdl_we[0] = st ? 1'b0 : D_we;
    mdl_a3[0] = st ? 5'd0 : D_A3;
    mdl_rs[0] = st ? 5'd0 : D_rs;
    mdl_rt[0] = st ? 5'd0 : D_rt;
    mdl_tn[0] = st ? 0 : int'(D_Tnew);
  endtask

  initial begin
    logic [10:0] e;
    vectors     = 0;
    miscompares = 0;

    // Reset with random D inputs, then all outputs must be quiet with D at zero.
    reset = 1'b1;
    drive($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 31),
          $urandom_range(0, 2));
    @(posedge clk); #1;
    drive($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 31),
          $urandom_range(0, 2));
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("reset_out", 11'd0);

`ifdef HAZ_FWD_EN
    add_rst();
    add("lu_lw",      29, 0, 1, 3, 1,  8, 2,  0, 0, 0, 0, 0, 0);
    add("lu_stall",    8, 0, 1, 1, 1, 10, 1,  1, 0, 0, 0, 0, 0);
    add("lu_release",  8, 0, 1, 1, 1, 10, 1,  0, 0, 0, 0, 0, 0);
    add("lu_fwd_w",    0, 0, 3, 3, 0,  0, 0,  0, 0, 0, 2, 0, 0);
    add_rst();
    add("lb_lw",      29, 0, 1, 3, 1,  9, 2,  0, 0, 0, 0, 0, 0);
    add("lb_stall1",   9, 0, 0, 0, 0,  0, 0,  1, 0, 0, 0, 0, 0);
    add("lb_stall2",   9, 0, 0, 0, 0,  0, 0,  1, 0, 0, 0, 0, 0);
    add("lb_grf",      9, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);
    add_rst();
    add("alu_addu",    1, 2, 1, 1, 1,  5, 1,  0, 0, 0, 0, 0, 0);
    add("alu_subu",    5, 5, 1, 1, 1,  6, 1,  0, 0, 0, 0, 0, 0);
    add("alu_fwd_m",   0, 0, 3, 3, 0,  0, 0,  0, 0, 0, 1, 1, 0);
    add("alu_fwd_mw",  0, 0, 3, 3, 0,  0, 0,  0, 0, 0, 0, 0, 1);
    add_rst();
    add("jal",         0, 0, 3, 3, 1, 31, 0,  0, 0, 0, 0, 0, 0);
    add("jr_fwd_e",   31, 0, 0, 3, 0,  0, 0,  0, 1, 0, 0, 0, 0);
    add_rst();
    add("zero_lw",    29, 0, 1, 3, 1,  0, 2,  0, 0, 0, 0, 0, 0);
    add("zero_use",    0, 0, 1, 1, 1, 10, 1,  0, 0, 0, 0, 0, 0);
    add_rst();
    add("st_addu",     1, 2, 1, 1, 1,  7, 1,  0, 0, 0, 0, 0, 0);
    add("st_nop",      0, 0, 3, 3, 0,  0, 0,  0, 0, 0, 0, 0, 0);
    add("st_fwd_m",    3, 7, 1, 2, 0,  0, 0,  0, 0, 2, 0, 0, 0);
    add_rst();
    add("tu3_addu",    1, 2, 1, 1, 1,  5, 1,  0, 0, 0, 0, 0, 0);
    add("tu3_use",     5, 5, 3, 3, 0,  0, 0,  0, 0, 0, 0, 0, 0);
    add_rst();
    add("rt_lw",      29, 0, 1, 3, 1,  4, 2,  0, 0, 0, 0, 0, 0);
    add("rt_stall",    0, 4, 1, 1, 1, 11, 1,  1, 0, 0, 0, 0, 0);
`else
    add_rst();
    add("lu_lw",      29, 0, 1, 3, 1,  8, 2,  0, 0, 0, 0, 0, 0);
    add("lu_stall1",   8, 0, 1, 1, 1, 10, 1,  1, 0, 0, 0, 0, 0);
    add("lu_stall2",   8, 0, 1, 1, 1, 10, 1,  1, 0, 0, 0, 0, 0);
    add("lu_release",  8, 0, 1, 1, 1, 10, 1,  0, 0, 0, 0, 0, 0);
    add_rst();
    add("lb_lw",      29, 0, 1, 3, 1,  9, 2,  0, 0, 0, 0, 0, 0);
    add("lb_stall1",   9, 0, 0, 0, 0,  0, 0,  1, 0, 0, 0, 0, 0);
    add("lb_stall2",   9, 0, 0, 0, 0,  0, 0,  1, 0, 0, 0, 0, 0);
    add("lb_grf",      9, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);
    add_rst();
    add("alu_addu",    1, 2, 1, 1, 1,  5, 1,  0, 0, 0, 0, 0, 0);
    add("alu_stall1",  5, 5, 1, 1, 1,  6, 1,  1, 0, 0, 0, 0, 0);
    add("alu_stall2",  5, 5, 1, 1, 1,  6, 1,  1, 0, 0, 0, 0, 0);
    add("alu_release", 5, 5, 1, 1, 1,  6, 1,  0, 0, 0, 0, 0, 0);
    add_rst();
    add("jal",         0, 0, 3, 3, 1, 31, 0,  0, 0, 0, 0, 0, 0);
    add("jr_stall1",  31, 0, 0, 3, 0,  0, 0,  1, 0, 0, 0, 0, 0);
    add("jr_stall2",  31, 0, 0, 3, 0,  0, 0,  1, 0, 0, 0, 0, 0);
    add("jr_release", 31, 0, 0, 3, 0,  0, 0,  0, 0, 0, 0, 0, 0);
    add_rst();
    add("zero_lw",    29, 0, 1, 3, 1,  0, 2,  0, 0, 0, 0, 0, 0);
    add("zero_use",    0, 0, 1, 1, 1, 10, 1,  0, 0, 0, 0, 0, 0);
    add_rst();
    add("tu3_addu",    1, 2, 1, 1, 1,  5, 1,  0, 0, 0, 0, 0, 0);
    add("tu3_use",     5, 5, 3, 3, 0,  0, 0,  0, 0, 0, 0, 0, 0);
    add_rst();
    add("rt_lw",      29, 0, 1, 3, 1,  4, 2,  0, 0, 0, 0, 0, 0);
    add("rt_stall",    0, 4, 1, 1, 1, 11, 1,  1, 0, 0, 0, 0, 0);
`endif

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      reset = tbl[i].rst;
      D_rs      = tbl[i].rs;
      D_rt      = tbl[i].rt;
      D_Tuse_rs = tbl[i].turs;
      D_Tuse_rt = tbl[i].turt;
      D_we      = tbl[i].we;
      D_A3      = tbl[i].a3;
      D_Tnew    = tbl[i].tnew;
      @(negedge clk);
      if (!tbl[i].rst) check(tbl[i].name, tbl[i].exp);
    end

    // Reset arriving while a load-use stall is active flushes the shadow state.
    @(posedge clk); #1;
    reset = 1'b1;
    drive(0, 0, 3, 3, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(29, 0, 1, 3, 1, 8, 2);
    @(posedge clk); #1;
    drive(8, 0, 1, 1, 1, 10, 1);
    @(negedge clk);
    check("rds_stall", 11'b11_00_00_00_00_0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rds_flush", 11'd0);

    // Randomized traffic on a small register set so hits are frequent.
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 2));
      @(negedge clk);
      e = model_out();
      check("random", e);
      if (reset) model_clear();
      else model_step(e[10]);
      @(posedge clk); #1;
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
